mem_arbiter: RTL

- Two-port round-robin arbiter and sequencer that shares the single-port 256x21 data memory between the processor core (port A) and the APB peripheral bridge (port B).
- Accepts one request per cycle from the two requesters and drives the memory's ce/wren/rden/addr/wr_data from registers.
- Tracks each in-flight read and returns read data to the requester that issued it.
- Sits between the core/bridge and the memory instance inside the processor subsystem.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer in front of a single-port data memory.
//   Port A (core) and port B (APB bridge) each present req/we/addr/wdata and
//   get a combinational gnt. The winner's command is registered onto the memory
//   interface (mem_ce/wren/rden/addr/wr_data). Every accepted read is followed
//   by a 2-stage tag pipe that raises x_rvalid on the issuing port two cycles
//   after the grant, when the memory's registered read data is on mem_rd_data.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   a_req/a_we/a_addr/a_wdata       port A command in
//   a_gnt, a_rvalid, a_rdata        port A accept / read return
//   b_*                             same for port B
//   mem_ce/wren/rden/addr/wr_data   registered memory command out
//   mem_rd_data                     memory registered read data in
module mem_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 21,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          mem_ce,
  output logic          mem_wren,
  output logic          mem_rden,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data
);

  logic          w_a_gnt;
  logic          w_b_gnt;
  logic          w_any_gnt;
  logic          w_win_we;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_wdata;

  logic          r_last_gnt_b;  // 1: B won the most recent grant
  logic          r_mem_ce;
  logic          r_mem_wren;
  logic          r_mem_rden;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wr_data;
  logic          r_tag_vld;     // stage 1: a read was issued last edge
  logic          r_tag_b;       // stage 1: that read belongs to port B
  logic          r_a_rvalid;
  logic          r_b_rvalid;

  // Grant decode; both grants held low during reset.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (rst_n) begin
      if (a_req && b_req) begin
        if (FIXED_PRI || r_last_gnt_b) begin
          w_a_gnt = 1'b1;
        end else begin
          w_b_gnt = 1'b1;
        end
      end else begin
        w_a_gnt = a_req;
        w_b_gnt = b_req;
      end
    end
  end

  assign w_any_gnt   = w_a_gnt | w_b_gnt;
  assign w_win_we    = w_b_gnt ? b_we    : a_we;
  assign w_win_addr  = w_b_gnt ? b_addr  : a_addr;
  assign w_win_wdata = w_b_gnt ? b_wdata : a_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_gnt_b  <= 1'b1;
      r_mem_ce      <= 1'b0;
      r_mem_wren    <= 1'b0;
      r_mem_rden    <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
      r_tag_vld     <= 1'b0;
      r_tag_b       <= 1'b0;
      r_a_rvalid    <= 1'b0;
      r_b_rvalid    <= 1'b0;
    end else begin
      r_mem_ce   <= w_any_gnt;
      r_mem_wren <= w_any_gnt & w_win_we;
      r_mem_rden <= w_any_gnt & ~w_win_we;
      if (w_any_gnt) begin
        r_last_gnt_b <= w_b_gnt;
        r_mem_addr   <= w_win_addr;
        if (w_win_we) begin
          r_mem_wr_data <= w_win_wdata;
        end
      end
      // Tag pipe advances every cycle so back-to-back reads never collide.
      r_tag_vld  <= w_any_gnt & ~w_win_we;
      r_tag_b    <= w_b_gnt;
      r_a_rvalid <= r_tag_vld & ~r_tag_b;
      r_b_rvalid <= r_tag_vld & r_tag_b;
    end
  end

  assign a_gnt       = w_a_gnt;
  assign b_gnt       = w_b_gnt;
  assign a_rvalid    = r_a_rvalid;
  assign b_rvalid    = r_b_rvalid;
  assign a_rdata     = mem_rd_data;
  assign b_rdata     = mem_rd_data;
  assign mem_ce      = r_mem_ce;
  assign mem_wren    = r_mem_wren;
  assign mem_rden    = r_mem_rden;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_mem_wr_data;

endmodule
